// File: rtl/drive_scheduler.sv
// Drive scheduler: sole owner of the four motion outputs. Conditions manual
// switches (with a stop dwell on gear reversal) or runs timed planner commands.
module drive_scheduler #(
  parameter int unsigned FWD_TICKS   = 500,
  parameter int unsigned TURN_TICKS  = 450,
  parameter int unsigned DWELL_TICKS = 250,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode_i,
  input  logic       man_throttle_i,
  input  logic       man_brake_i,
  input  logic       man_reverse_i,
  input  logic       man_left_i,
  input  logic       man_right_i,
  input  logic       semi_valid_i,
  input  logic [2:0] semi_cmd_i,
  output logic       semi_ready_o,
  input  logic       auto_valid_i,
  input  logic [2:0] auto_cmd_i,
  output logic       auto_ready_o,
  output logic       move_fwd_o,
  output logic       move_back_o,
  output logic       turn_left_o,
  output logic       turn_right_o,
  output logic       cmd_done_o,
  output logic       cmd_abort_o,
  output logic       cmd_err_o
);

  typedef enum logic [2:0] {
    OFF,
    MAN_RUN,
    MAN_DWELL,
    CMD_IDLE,
    CMD_EXEC
  } state_e;

  localparam logic [1:0] ModeOff  = 2'b00;
  localparam logic [1:0] ModeMan  = 2'b01;
  localparam logic [1:0] ModeSemi = 2'b11;

  localparam logic [CNT_W-1:0] FwdLast   = CNT_W'(FWD_TICKS - 1);
  localparam logic [CNT_W-1:0] TurnLast  = CNT_W'(TURN_TICKS - 1);
  localparam logic [CNT_W-1:0] UturnLast = CNT_W'(2 * TURN_TICKS - 1);
  localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_TICKS - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q;
  logic             lastDir_q, lastDir_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [3:0]       motion_q, motion_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;

  logic       manGo, manFwd, manBack, manLeft, manRight;
  logic       accept;
  logic [2:0] selCmd;

  // Motion vector ordering used throughout: {fwd, back, left, right}
  function automatic logic [3:0] cmdMotion(input logic [2:0] cmd);
    case (cmd)
      3'b001:  cmdMotion = 4'b1000;
      3'b010:  cmdMotion = 4'b1010;
      3'b011:  cmdMotion = 4'b1001;
      3'b100:  cmdMotion = 4'b1010;
      default: cmdMotion = 4'b0000;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] cmdLast(input logic [2:0] cmd);
    case (cmd)
      3'b001:         cmdLast = FwdLast;
      3'b010, 3'b011: cmdLast = TurnLast;
      default:        cmdLast = UturnLast;
    endcase
  endfunction

  assign manGo    = man_throttle_i & ~man_brake_i;
  assign manFwd   = manGo & ~man_reverse_i;
  assign manBack  = manGo & man_reverse_i;
  assign manLeft  = man_left_i & ~man_right_i;
  assign manRight = man_right_i & ~man_left_i;

  assign semi_ready_o = (state_q == CMD_IDLE) && (mode_q == ModeSemi);
  assign auto_ready_o = (state_q == CMD_IDLE) && (mode_q == 2'b10);
  assign accept       = (semi_valid_i & semi_ready_o) | (auto_valid_i & auto_ready_o);
  assign selCmd       = (mode_q == ModeSemi) ? semi_cmd_i : auto_cmd_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lastDir_d = lastDir_q;
    cmd_d     = cmd_q;
    motion_d  = 4'b0000;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    err_d     = 1'b0;

    if (mode_i != mode_q) begin
      cnt_d   = '0;
      abort_d = (state_q == CMD_EXEC);
      case (mode_i)
        ModeOff: state_d = OFF;
        ModeMan: state_d = MAN_RUN;
        default: state_d = CMD_IDLE;
      endcase
    end else begin
      case (state_q)
        MAN_RUN: begin
          motion_d[1:0] = {manLeft, manRight};
          // A gear flip while the car is still rolling must stop it first
          if (manGo && (man_reverse_i != lastDir_q) && (motion_q[3] | motion_q[2])) begin
            state_d = MAN_DWELL;
            cnt_d   = '0;
          end else begin
            motion_d[3:2] = {manFwd, manBack};
          end
        end
        MAN_DWELL: begin
          motion_d[1:0] = {manLeft, manRight};
          if (cnt_q == DwellLast) begin
            state_d       = MAN_RUN;
            cnt_d         = '0;
            motion_d[3:2] = {manFwd, manBack};
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        CMD_IDLE: begin
          if (accept) begin
            cmd_d = selCmd;
            case (selCmd)
              3'b000: done_d = 1'b1;
              3'b001, 3'b010, 3'b011, 3'b100: begin
                state_d  = CMD_EXEC;
                cnt_d    = '0;
                motion_d = cmdMotion(selCmd);
              end
              default: begin
                done_d = 1'b1;
                err_d  = 1'b1;
              end
            endcase
          end
        end
        CMD_EXEC: begin
          if (cnt_q == cmdLast(cmd_q)) begin
            state_d = CMD_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d    = cnt_q + CntOne;
            motion_d = cmdMotion(cmd_q);
          end
        end
        default: state_d = OFF;
      endcase
    end

    if (motion_d[3]) begin
      lastDir_d = 1'b0;
    end else if (motion_d[2]) begin
      lastDir_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      mode_q    <= 2'b00;
      lastDir_q <= 1'b0;
      cmd_q     <= 3'b000;
      motion_q  <= 4'b0000;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_i;
      lastDir_q <= lastDir_d;
      cmd_q     <= cmd_d;
      motion_q  <= motion_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      err_q     <= err_d;
    end
  end

  assign move_fwd_o   = motion_q[3];
  assign move_back_o  = motion_q[2];
  assign turn_left_o  = motion_q[1];
  assign turn_right_o = motion_q[0];
  assign cmd_done_o   = done_q;
  assign cmd_abort_o  = abort_q;
  assign cmd_err_o    = err_q;

endmodule

// File: doc/drive_scheduler.md
Name: drive_scheduler

Overview:
Sequences the car's motion outputs from the drive mode produced by the power/mode controller. In manual mode it conditions the driver's switch inputs and enforces a stop dwell on gear reversal. In semi-auto and auto modes it executes timed motion commands accepted over a valid/ready handshake from the respective planner. It is the single owner of the four motion outputs feeding the vehicle model.

Parameters:
FWD_TICKS, 500, cycles a forward command drives move_fwd (1 s at 2 ms tick)
TURN_TICKS, 450, cycles a left/right turn drives its turn output
DWELL_TICKS, 250, forced-stop cycles on manual gear reversal while moving
CNT_W, 32, width of the internal tick counter

Ports:
clk  in  1  system tick clock
rst  in  1  asynchronous active-high reset
mode  in  2  00 off, 01 manual, 11 semi-auto, 10 auto
man_throttle  in  1  manual throttle
man_brake  in  1  manual brake, overrides throttle
man_reverse  in  1  manual gear: 0 forward, 1 reverse
man_left  in  1  manual left turn
man_right  in  1  manual right turn
semi_valid  in  1  semi-auto command valid
semi_cmd  in  3  semi-auto command
semi_ready  out  1  semi-auto command accepted when valid&ready
auto_valid  in  1  auto command valid
auto_cmd  in  3  auto command
auto_ready  out  1  auto command accepted when valid&ready
move_fwd  out  1  drive forward
move_back  out  1  drive backward
turn_left  out  1  steer left
turn_right  out  1  steer right
cmd_done  out  1  one-cycle pulse: command completed
cmd_abort  out  1  one-cycle pulse: executing command cancelled
cmd_err  out  1  one-cycle pulse: illegal command accepted

Behaviour:
- Reset: state OFF, counter 0, mode_q 00, all outputs 0, last_dir forward.
- mode_q registers mode each cycle; mode != mode_q forces next state to the new mode's entry state (OFF, MAN_RUN, CMD_IDLE), counter cleared, motion outputs 0 for that cycle; cmd_abort pulses if leaving CMD_EXEC. cmd_done never fires on abort. Mode change takes priority over all other transitions.
- States: OFF, MAN_RUN, MAN_DWELL, CMD_IDLE, CMD_EXEC.
- OFF: all outputs 0, ready 0.
- MAN_RUN: outputs registered, 1-cycle latency. move_fwd = throttle & ~brake & ~reverse; move_back = throttle & ~brake & reverse; turn_left = left & ~right; turn_right = right & ~left. last_dir updates whenever a move output is 1. If the gear requested with throttle&~brake differs from last_dir and the previous cycle had a move output high -> MAN_DWELL, motion 0.
- MAN_DWELL: move outputs 0, turn outputs follow switches; count DWELL_TICKS cycles, then MAN_RUN. Brake does not shorten dwell.
- Semi/auto: semi_ready = (state==CMD_IDLE)&(mode_q==11); auto_ready = (state==CMD_IDLE)&(mode_q==10); combinational; the non-selected ready is always 0.
- Accept in CMD_IDLE on valid&ready: latch cmd, next cycle CMD_EXEC. Commands: 000 stop, 001 forward (move_fwd, FWD_TICKS), 010 left (turn_left+move_fwd, TURN_TICKS), 011 right (turn_right+move_fwd, TURN_TICKS), 100 U-turn (turn_left+move_fwd, 2*TURN_TICKS). 000 and 101-111 execute zero cycles: CMD_IDLE remains, cmd_done pulses next cycle; 101-111 also pulse cmd_err that cycle.
- CMD_EXEC: outputs asserted for exactly the command's tick count, then CMD_IDLE with cmd_done=1 in that first idle cycle; ready is high in that same cycle (back-to-back commands have no gap in ready, one 0-output cycle between executions).
- Valid while not ready is ignored; no queuing. Manual inputs are ignored outside manual mode.
- Counter compares at N-1 like other tick counters in the design; never wraps.

Test Plan:
(bench uses FWD_TICKS=8, TURN_TICKS=5, DWELL_TICKS=3)
- rst pulse mid-EXEC, async between edges -> all outputs 0 immediately, state OFF, no cmd_done.
- mode 01, throttle=1 reverse=0 -> move_fwd=1 one cycle later; brake=1 -> move_fwd=0 next cycle.
- mode 01 driving forward, reverse=1 -> 3 cycles move_back=move_fwd=0, then move_back=1.
- mode 11, semi_cmd=010 valid -> accept, turn_left&move_fwd high 5 cycles, cmd_done pulse, semi_ready=1; auto_ready stays 0.
- mode 10, auto_cmd=100 -> 10 cycles turn_left; mode->01 at cycle 4 -> cmd_abort pulse, outputs 0, no cmd_done.
- mode 11, semi_cmd=111 -> cmd_err and cmd_done pulse, no motion output.
